// File: rtl/m_mem_arbiter.sv
// rtl/m_mem_arbiter.sv - round-robin sharing of the data-memory port between CPU M-stage and bridge/DMA
// Captures one request at a time, runs the mem handshake with a response timeout, pulses per-port done.

module m_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [3:0]  p0_be,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [3:0]  p1_be,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [3:0]        sel_be;

  // win=1 selects port 1; rr_q=1 means port 1 has priority on a tie
  always_comb begin
    any_req = p0_req | p1_req;
    win     = p1_req & (~p0_req | rr_q);
    sel_we  = win ? p1_we : p0_we;
    sel_be  = win ? p1_be : p0_be;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = win;
          we_d    = sel_we;
          addr_d  = win ? p1_addr : p0_addr;
          be_d    = sel_be;
          wdata_d = win ? p1_wdata : p0_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          gnt_d   = win ? 2'b10 : 2'b01;
          // A write with no lanes enabled completes without touching memory
          state_d = (sel_we && (sel_be == 4'b0000)) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = we_q ? 32'h0 : mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  logic in_resp;

  always_comb begin
    in_resp   = (state_q == S_RESP);
    mem_req   = (state_q == S_ISSUE);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? (addr_q & 32'hFFFF_FFFC) : 32'h0;
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_wdata = mem_req ? wdata_q : 32'h0;
    p0_gnt    = gnt_q[0];
    p1_gnt    = gnt_q[1];
    p0_done   = in_resp & ~owner_q;
    p1_done   = in_resp & owner_q;
    p0_rdata  = p0_done ? rdata_q : 32'h0;
    p1_rdata  = p1_done ? rdata_q : 32'h0;
    err       = in_resp & err_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb/tb_m_mem_arbiter.sv - randomized scoreboard bench for m_mem_arbiter
// Requesters push expected responses; a monitor pops them on each done pulse.

module tb_m_mem_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_r   [2];
  logic        we_r    [2];
  logic [31:0] addr_r  [2];
  logic [3:0]  be_r    [2];
  logic [31:0] wd_r    [2];
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_we, mem_ack, mem_rvalid, err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // Per-port transaction descriptors shared with the memory model
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [3:0]  d_be    [2];
  logic [31:0] d_wdata [2];
  int          d_ack   [2];
  int          d_k     [2];
  logic [31:0] d_rdata [2];

  exp_t eq0[$];
  exp_t eq1[$];
  logic gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  int   ndone  = 0;

  m_mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(req_r[0]), .p0_we(we_r[0]), .p0_addr(addr_r[0]), .p0_be(be_r[0]), .p0_wdata(wd_r[0]),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(req_r[1]), .p1_we(we_r[1]), .p1_addr(addr_r[1]), .p1_be(be_r[1]), .p1_wdata(wd_r[1]),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_txn(input int p, input int gap, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input int ack,
                        input int k, input logic [31:0] rdata);
    exp_t e;
    logic noop, to, done;
    repeat (gap) begin @(posedge clk); #1; end
    noop    = we && (be == 4'b0000);
    to      = !noop && (k > TO);
    e.rdata = (noop || we || to) ? 32'h0 : rdata;
    e.err   = to;
    e.lat   = noop ? 0 : ack + 1 + (to ? TO : k);
    if (p == 0) eq0.push_back(e); else eq1.push_back(e);
    d_we[p] = we; d_addr[p] = addr; d_be[p] = be; d_wdata[p] = wdata;
    d_ack[p] = ack; d_k[p] = k; d_rdata[p] = rdata;
    we_r[p] = we; addr_r[p] = addr; be_r[p] = be; wd_r[p] = wdata;
    req_r[p] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (p == 0) ? p0_done : p1_done;
    end
    chk("done_seen", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    req_r[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] a, wd, rd;
    logic [3:0]  be;
    logic        we;
    for (int i = 0; i < n; i++) begin
      a     = $urandom;
      a[31] = p[0];
      wd    = $urandom;
      rd    = $urandom;
      we    = 1'($urandom % 2);
      be    = ($urandom % 4 == 0) ? 4'b0000 : 4'($urandom);
      do_txn(p, $urandom_range(0, 3), we, a, be, wd, $urandom_range(0, 3),
             $urandom_range(1, TO + 2), rd);
    end
  endtask

  // Memory model: acks after the descriptor's delay, answers on WAIT cycle k
  initial begin
    int   n_iss, wcnt, wp;
    logic in_wait;
    n_iss = 0; wcnt = 0; wp = 0; in_wait = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!reset) begin
        in_wait = 1'b0; n_iss = 0;
      end else if (mem_req) begin
        wp = int'(mem_addr[31]);
        chk("mem_addr", mem_addr, d_addr[wp] & 32'hFFFF_FFFC);
        chk("mem_we", {31'h0, mem_we}, {31'h0, d_we[wp]});
        chk("mem_be", {28'h0, mem_be}, {28'h0, d_be[wp]});
        chk("mem_wdata", mem_wdata, d_wdata[wp]);
        chk("mem_req_in_wait", {31'h0, in_wait}, 32'h0);
        if (n_iss >= d_ack[wp]) begin
          mem_ack = 1'b1; n_iss = 0; in_wait = 1'b1; wcnt = 0;
        end else begin
          n_iss++;
        end
      end else if (in_wait) begin
        wcnt++;
        if (wcnt == d_k[wp]) begin
          mem_rvalid = 1'b1;
          mem_rdata  = d_rdata[wp];
        end
        if (wcnt == d_k[wp] || wcnt >= TO) in_wait = 1'b0;
      end else begin
        mem_ack    = 1'($urandom % 2);
        mem_rvalid = 1'($urandom % 2);
      end
    end
  end

  // Monitor: arbitration rule, scoreboard pops, busy and idle-output checks
  initial begin
    int          cyc, gcyc;
    logic        in_txn, last_v, last_o, own, pd;
    logic [1:0]  prev, g, expg;
    exp_t        e;
    cyc = 0; gcyc = 0; in_txn = 1'b0; last_v = 1'b0; last_o = 1'b0; own = 1'b0;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        in_txn = 1'b0; last_v = 1'b0; prev = 2'b00;
        continue;
      end
      g = {p1_gnt, p0_gnt};
      if (g != 2'b00) begin
        if (prev == 2'b11) expg = (last_v && !last_o) ? 2'b10 : 2'b01;
        else expg = prev;
        chk("gnt_winner", {30'h0, g}, {30'h0, expg});
        own = g[1]; gcyc = cyc; in_txn = 1'b1;
        gnt_log.push_back(g[1]);
      end
      if (p0_done || p1_done) begin
        chk("done_onehot", {31'h0, p0_done & p1_done}, 32'h0);
        pd = p1_done;
        chk("done_owner", {31'h0, pd}, {31'h0, own});
        if ((pd ? eq1.size() : eq0.size()) == 0) begin
          chk("done_expected", 32'h1, 32'h0);
        end else begin
          e = pd ? eq1.pop_front() : eq0.pop_front();
          chk("rdata", pd ? p1_rdata : p0_rdata, e.rdata);
          chk("err", {31'h0, err}, {31'h0, e.err});
          chk("latency", cyc - gcyc, e.lat);
        end
        chk("other_rdata", pd ? p0_rdata : p1_rdata, 32'h0);
        chk("busy_resp", {31'h0, busy}, 32'h1);
        last_v = 1'b1; last_o = pd; in_txn = 1'b0;
        ndone++;
      end else begin
        chk("idle_outputs", p0_rdata | p1_rdata | {31'h0, err}, 32'h0);
        chk("busy", {31'h0, busy}, {31'h0, in_txn});
      end
      prev = {req_r[1], req_r[0]};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ord;
    int         nd0;
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_r[p] = 1'b0; we_r[p] = 1'b0; addr_r[p] = 32'h0; be_r[p] = 4'h0; wd_r[p] = 32'h0;
      d_we[p] = 1'b0; d_addr[p] = 32'h0; d_be[p] = 4'h0; d_wdata[p] = 32'h0;
      d_ack[p] = 0; d_k[p] = 1; d_rdata[p] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {25'h0, busy, mem_req, p0_gnt, p1_gnt, p0_done, p1_done, err}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Both held from reset: p0, p1, p0, p1
    fork
      begin
        do_txn(0, 0, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0, 1, 32'h1111_1111);
        do_txn(0, 0, 1'b1, 32'h0000_0104, 4'h3, 32'h0000_BEEF, 1, 2, 32'h2222_2222);
      end
      begin
        do_txn(1, 0, 1'b0, 32'h8000_0200, 4'hF, 32'h0, 2, 1, 32'h3333_3333);
        do_txn(1, 0, 1'b0, 32'h8000_0204, 4'hC, 32'h0, 0, 3, 32'h4444_4444);
      end
    join
    ord = 4'hF;
    if (gnt_log.size() == 4) ord = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]};
    chk("rr_order", {28'h0, ord}, 32'h5);

    do_txn(0, 1, 1'b0, 32'h0000_1006, 4'b1100, 32'h0, 0, 1, 32'hAABB_CCDD);
    do_txn(1, 1, 1'b1, 32'h8000_0040, 4'b0001, 32'h0000_005A, 3, 2, 32'h9999_9999);
    do_txn(0, 1, 1'b0, 32'h0000_3000, 4'hF, 32'h0, 0, TO + 1, 32'h5555_5555);
    do_txn(0, 1, 1'b0, 32'h0000_3004, 4'hF, 32'h0, 0, TO, 32'h6666_6666);
    do_txn(0, 1, 1'b1, 32'h0000_3008, 4'b0000, 32'h1234_5678, 0, 1, 32'h7777_7777);

    fork
      rand_port(0, 120);
      rand_port(1, 120);
    join

    // Reset during WAIT: outputs clear at once, no done pulse
    d_we[0] = 1'b0; d_addr[0] = 32'h0000_2000; d_be[0] = 4'hF; d_wdata[0] = 32'h0;
    d_ack[0] = 0; d_k[0] = TO + 5; d_rdata[0] = 32'h0;
    we_r[0] = 1'b0; addr_r[0] = 32'h0000_2000; be_r[0] = 4'hF; wd_r[0] = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    nd0 = ndone;
    req_r[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_before_reset", {31'h0, busy}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {25'h0, busy, mem_req, p0_gnt, p1_gnt, p0_done, p1_done, err}, 32'h0);
    req_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("no_done_after_reset", ndone, nd0);

    gnt_log.delete();
    fork
      do_txn(0, 0, 1'b0, 32'h0000_0500, 4'hF, 32'h0, 1, 1, 32'hCAFE_0000);
      do_txn(1, 0, 1'b0, 32'h8000_0500, 4'hF, 32'h0, 0, 1, 32'hCAFE_0001);
    join
    chk("post_reset_first_gnt", (gnt_log.size() > 0) ? {31'h0, gnt_log[0]} : 32'hFF, 32'h0);

    repeat (3) @(posedge clk);
    chk("eq0_empty", eq0.size(), 32'h0);
    chk("eq1_empty", eq1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_mem_arbiter.md
Name: m_mem_arbiter

Overview:
Sequences and shares the single data-memory port between two requesters. Port 0 is the CPU M-stage, which supplies byte-lane-aligned write data and byte enables. Port 1 is the external bridge/DMA. The block performs round-robin arbitration, a request/ack/response handshake with the memory, per-port completion pulses, and a response timeout. It sits between the M-stage byte-enable logic and the data memory, and its busy output feeds the pipeline stall logic.

Parameters:
TIMEOUT, 255, max cycles waited in WAIT for mem_rvalid before forcing an error response (1..2^CNT_W-1)
CNT_W, 8, width of timeout counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
p0_req  input  1  port 0 request; held stable until p0_done
p0_we  input  1  port 0 write (1) / read (0)
p0_addr  input  32  port 0 byte address
p0_be  input  4  port 0 byte enables, bit i = byte lane i
p0_wdata  input  32  port 0 lane-aligned write data
p0_gnt  output  1  one-cycle pulse: port 0 request captured
p0_done  output  1  one-cycle pulse: port 0 transaction complete
p0_rdata  output  32  port 0 read data, valid while p0_done=1
p1_req, p1_we, p1_addr, p1_be, p1_wdata, p1_gnt, p1_done, p1_rdata  same as port 0, for port 1
mem_req  output  1  memory request valid
mem_we  output  1  memory write
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  memory byte enables
mem_wdata  output  32  memory write data
mem_ack  input  1  memory accepts request (same cycle as mem_req)
mem_rvalid  input  1  memory response; for writes, signals completion
mem_rdata  input  32  memory read data, valid with mem_rvalid
err  output  1  one-cycle pulse with pX_done when the transaction timed out
busy  output  1  state != IDLE

Behaviour:
- All outputs are registered or decoded from state. Reset (reset=0, asynchronous) forces:
  - state=IDLE, all outputs 0, rr_ptr=0, counter=0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pX_req=1, select the winner: rr_ptr=0 prefers p0, rr_ptr=1 prefers p1; a lone requester always wins.
  - At the clock edge, capture the winner's we/addr/be/wdata and the owner id, and pulse pX_gnt for one cycle.
  - If we=1 and be=4'b0000: go directly to RESP (no-op write, memory untouched).
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive mem_req=1 with the captured fields.
  - Stay in ISSUE until mem_ack=1, then go to WAIT with counter cleared.
  - Captured fields stay stable throughout ISSUE.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: latch mem_rdata (forced to 0 for writes) and go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and mem_rvalid=0: latch rdata=0, set the error flag, and go to RESP.
  - mem_rvalid arriving in the same cycle the timeout hits counts as success (no error).
- RESP:
  - Exactly one cycle.
  - Owner's pX_done=1 and pX_rdata=latched data; err=error flag. The non-owner's done and rdata stay 0.
  - rr_ptr becomes ~owner.
  - Go to IDLE.
- Requesters drop req on the edge ending their done cycle. Arbitration in the next IDLE cycle therefore sees updated requests.
  - Minimum latency is 4 cycles from req to done (IDLE, ISSUE with ack, WAIT with rvalid, RESP).
  - One IDLE cycle separates back-to-back transactions.
- mem_rvalid/mem_ack outside ISSUE/WAIT are ignored. pX_req changes outside IDLE are ignored.
- The block does not modify be or wdata. Lane alignment is the requester's responsibility.

Test Plan:
- Single read: p0 read, addr=0x0000_1006, be=4'b1100; mem_ack immediate, rvalid next cycle with rdata=0xAABB_CCDD -> mem_addr=0x0000_1004, mem_be=1100, p0_done on cycle 4 with p0_rdata=0xAABB_CCDD, err=0.
- Contention/round-robin: p0 and p1 both request from reset, held -> order p0, p1, p0, p1. Each gnt/done goes only to its owner; busy stays high except the single IDLE cycles between transactions.
- Ack backpressure: p1 write be=4'b0001, wdata=0x0000_005A, mem_ack low for 3 cycles -> mem_req and fields stable 3 cycles, then WAIT; rvalid -> p1_done, p1_rdata=0.
- Timeout: TIMEOUT=4, p0 read, ack given, no rvalid -> p0_done with err=1 and rdata=0, exactly 4 WAIT cycles. Repeat with rvalid on the 4th WAIT cycle -> err=0.
- No-op write: p0 we=1, be=0 -> mem_req never asserted, p0_done 2 cycles after req (IDLE→RESP).
- Reset mid-op: assert reset=0 during WAIT -> outputs 0 immediately (asynchronous), no done pulse. After release, the next simultaneous request grants p0.
